// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with a skid-buffered valid/ready output.
// Define LOGIC_UNIT_FLAGS_EN to build the zero/ones/parity flag registers.
module logic_unit_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    logic             m_valid;
    logic             s_valid;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] s_data;
    logic [WIDTH-1:0] res;
    logic             accept;
    logic             m_free;

    always_comb begin
        res = '0;
        unique case (op)
            3'b000: res = x & y;
            3'b001: res = x | y;
            3'b010: res = x ^ y;
            3'b011: res = ~(x ^ y);
            3'b100: res = ~(x & y);
            3'b101: res = ~(x | y);
            3'b110: res = ~x;
            3'b111: res = x;
        endcase
    end

    // in_ready comes straight from a register, so it never sees out_ready
    assign in_ready  = !s_valid;
    assign accept    = in_valid && !s_valid;
    assign m_free    = !m_valid || out_ready;
    assign out_valid = m_valid;
    assign out       = m_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (m_free) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                s_valid <= accept;
                if (accept) s_data <= res;
            end else begin
                m_valid <= accept;
                if (accept) m_data <= res;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_data  <= res;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    // flags travel with their entry: {zero, ones, parity}
    logic [2:0] m_flg;
    logic [2:0] s_flg;
    logic [2:0] res_flg;

    assign res_flg = {~|res, &res, ^res};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_flg <= '0;
            s_flg <= '0;
        end else if (m_free) begin
            if (s_valid) begin
                m_flg <= s_flg;
                if (accept) s_flg <= res_flg;
            end else if (accept) begin
                m_flg <= res_flg;
            end
        end else if (accept) begin
            s_flg <= res_flg;
        end
    end

    assign zero   = m_flg[2];
    assign ones   = m_flg[1];
    assign parity = m_flg[0];
`else
    assign zero   = 1'b0;
    assign ones   = 1'b0;
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe (WIDTH=4 lane plus a WIDTH=8
// lane for the flag checks).
module tb_logic_unit_pipe;

`ifdef LOGIC_UNIT_FLAGS_EN
    localparam bit FLG = 1'b1;
`else
    localparam bit FLG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv, ir, ov, ordy, z, o, p;
    logic [2:0] op;
    logic [3:0] x, y, q;
    logic       b_iv, b_ir, b_ov, b_ordy, b_z, b_o, b_p;
    logic [2:0] b_op;
    logic [7:0] b_x, b_y, b_q;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir), .op(op), .x(x), .y(y),
        .out_valid(ov), .out_ready(ordy), .out(q),
        .zero(z), .ones(o), .parity(p)
    );

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir), .op(b_op), .x(b_x), .y(b_y),
        .out_valid(b_ov), .out_ready(b_ordy), .out(b_q),
        .zero(b_z), .ones(b_o), .parity(b_p)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_lu(input logic [2:0] f,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a ^ b);
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic chk_flags(input string tag, input logic [3:0] r);
        chk({tag, ".zero"}, z, FLG & (r == 4'h0));
        chk({tag, ".ones"}, o, FLG & (r == 4'hf));
        chk({tag, ".par"},  p, FLG & (^r));
    endtask

    // one beat in, result checked the cycle after acceptance
    task automatic beat(input string tag, input logic [2:0] f,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp);
        iv = 1'b1; op = f; x = a; y = b;
        tick();
        iv = 1'b0;
        chk({tag, ".ov"}, ov, 1'b1);
        chk({tag, ".out"}, q, exp);
        chk_flags(tag, exp);
    endtask

    typedef struct {
        logic [2:0] f;
        logic [3:0] e;
    } vec_t;

    vec_t tbl[8] = '{
        '{3'd3, 4'b0100}, '{3'd2, 4'b1011}, '{3'd4, 4'b1011},
        '{3'd6, 4'b0010}, '{3'd0, 4'b0100}, '{3'd1, 4'b1111},
        '{3'd5, 4'b0000}, '{3'd7, 4'b1101}
    };

    initial begin
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b1;
        op = '0; x = '0; y = '0;
        b_iv = 1'b0; b_ordy = 1'b1; b_op = '0; b_x = '0; b_y = '0;
        tick(); tick();
        chk("rst.ov", ov, 1'b0);
        chk("rst.ir", ir, 1'b1);
        chk("rst.out", q, 4'h0);
        chk("rst.flags", {z, o, p}, 3'b000);
        rst_n = 1'b1;
        tick();

        // first beat: 1000 XNOR 1001 = 1110
        beat("xnor0", 3'd3, 4'b1000, 4'b1001, 4'b1110);
        tick();
        chk("idle.ov", ov, 1'b0);

        // x=1101, y=0110 through every op
        foreach (tbl[i]) begin
            beat($sformatf("op%0d", tbl[i].f), tbl[i].f,
                 4'b1101, 4'b0110, tbl[i].e);
        end
        tick();

        // back-pressure: 1010&0110=0010, 1010|0110=1110
        ordy = 1'b0;
        iv = 1'b1; op = 3'd0; x = 4'b1010; y = 4'b0110;
        chk("bp.ir0", ir, 1'b1);
        tick();
        chk("bp.ir1", ir, 1'b1);
        chk("bp.out1", q, 4'b0010);
        op = 3'd1;
        tick();
        chk("bp.ir2", ir, 1'b0);
        op = 3'd2; x = 4'b1111; y = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp.stall%0d.ir", k), ir, 1'b0);
            chk($sformatf("bp.stall%0d.ov", k), ov, 1'b1);
            chk($sformatf("bp.stall%0d.out", k), q, 4'b0010);
        end
        iv = 1'b0; ordy = 1'b1;
        tick();
        chk("bp.rel.ov", ov, 1'b1);
        chk("bp.rel.out", q, 4'b1110);
        chk("bp.rel.ir", ir, 1'b1);
        tick();
        chk("bp.drain.ov", ov, 1'b0);

        // streaming, one beat per cycle, ops cycling
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a, b;
            a = 4'(i);
            b = 4'(i * 5 + 3);
            iv = 1'b1; op = 3'(i); x = a; y = b;
            tick();
            chk($sformatf("strm%0d.ov", i), ov, 1'b1);
            chk($sformatf("strm%0d.out", i), q, ref_lu(3'(i), a, b));
            chk($sformatf("strm%0d.ir", i), ir, 1'b1);
        end
        iv = 1'b0;
        tick();
        chk("strm.end.ov", ov, 1'b0);

        // reset with both entries full
        ordy = 1'b0;
        iv = 1'b1; op = 3'd7; x = 4'b0101;
        tick();
        x = 4'b0110;
        tick();
        iv = 1'b0;
        chk("mr.full.ir", ir, 1'b0);
        chk("mr.full.ov", ov, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr.ov", ov, 1'b0);
        chk("mr.ir", ir, 1'b1);
        chk("mr.out", q, 4'h0);
        ordy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("mr.after%0d.ov", k), ov, 1'b0);
        end

        // WIDTH=8 flags
        b_iv = 1'b1; b_op = 3'd0; b_x = 8'h00; b_y = 8'h00;
        tick();
        chk("w8.and.out", b_q, 8'h00);
        chk("w8.and.zero", b_z, FLG);
        chk("w8.and.ones", b_o, 1'b0);
        b_op = 3'd5;
        tick();
        b_iv = 1'b0;
        chk("w8.nor.out", b_q, 8'hff);
        chk("w8.nor.ones", b_o, FLG);
        chk("w8.nor.zero", b_z, 1'b0);
        chk("w8.nor.par", b_p, 1'b0);
        b_iv = 1'b1; b_op = 3'd7; b_x = 8'h07;
        tick();
        b_iv = 1'b0;
        chk("w8.pass.out", b_q, 8'h07);
        chk("w8.pass.par", b_p, FLG);
        tick();
        chk("w8.idle.ov", b_ov, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
